writeback_queue: RTL
====================

Name: writeback_queue

Overview:
- Write-side front end for the 16x16 register file: collects result write requests from the ALU/multiply-divide unit and from the load-return path.
- Orders the requests and issues at most one register-file write command per cycle, on the same port set the register file consumes (registerWrite, regWriteLocal, dataWrite, r0Write).
- Buffers collisions in a small FIFO.
- Reports pending-write hazards to the decode stage.

Parameters:
- DEPTH, 4, FIFO entries behind the output stage (power of two, at least 2).

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- aluValid  input  1  ALU request present
- aluDestEn  input  1  ALU request writes Rd
- aluDest  input  4  Rd index
- aluResult  input  16  Rd data
- aluR0En  input  1  ALU request also writes R0 (mul high word / div remainder)
- aluR0Result  input  16  R0 data
- memValid  input  1  load-return request present; always Rd-only
- memDest  input  4  load destination
- memData  input  16  load data
- stall  output  1  producers must hold; no request accepted
- registerWrite  output  2  bit1 = R0 write, bit0 = Rd write
- regWriteLocal  output  4  Rd index
- dataWrite  output  16  Rd data
- r0Write  output  16  R0 data
- queryA  input  4  decode read index A
- queryB  input  4  decode read index B
- pendingA  output  1  write to queryA outstanding
- pendingB  output  1  write to queryB outstanding

Behaviour:
- Clock and reset: one clock (clk); reset_n is asynchronous and active-low.
- Reset: FIFO emptied (count=0, pointers 0); output stage invalid; registerWrite=00, regWriteLocal=0, dataWrite=0, r0Write=0. stall=0 after reset. Assertion mid-operation discards all queued writes immediately.
- Entry format: {dEn, dest, dData, r0En, r0Data}.
  - ALU request maps to {aluDestEn, aluDest, aluResult, aluR0En, aluR0Result}.
  - MEM request maps to {1, memDest, memData, 0, 0}.
  - An ALU request with aluDestEn=0 and aluR0En=0 is dropped and never enqueued.
- stall: combinational, 1 when free FIFO slots < 2 (count > DEPTH-2). While stall=1, aluValid and memValid are ignored entirely.
- Ordering at every rising edge, oldest first: FIFO entries, then the accepted ALU request, then the accepted MEM request.
  - The output stage loads the oldest available entry.
  - The remaining accepted requests are pushed to the FIFO in the same order.
  - Net FIFO change per cycle ranges from -1 to +1.
- Latency:
  - With the FIFO empty, a request sampled at edge E drives the write outputs during cycle E..E+1, so the register file commits at edge E+1.
  - Each older queued entry adds one cycle.
- Output stage:
  - registerWrite = {r0En, dEn} of the loaded entry; 00 when nothing is loaded.
  - Data and index outputs hold their last values when idle.
  - One write command per cycle maximum; outputs are registered.
- Entry with dest=0, dEn=1 and r0En=1: both bits are issued. The register file resolves this with dataWrite winning. No merging or reordering is done here.
- Hazard flags (combinational): pendingX=1 if the valid output stage or any valid FIFO entry has (dEn and dest==queryX), or (r0En and queryX==0). Requests in the current cycle are not counted.
- FIFO pointers wrap modulo DEPTH. Overflow is impossible by construction of stall; overflow is an assertion failure in the bench.

Test Plan:
- Reset mid-stream: with 3 entries queued, pull reset_n low -> registerWrite=00, stall=0, pendingA=0 immediately, with no clock edge needed.
- Single ALU op on empty queue: aluValid, aluDestEn=1, aluDest=3, aluResult=16'h1234 -> the next cycle shows registerWrite=01, regWriteLocal=3, dataWrite=16'h1234; the cycle after shows registerWrite=00.
- Multiply result: aluDestEn=1, aluDest=5, aluResult=16'h0051, aluR0En=1, aluR0Result=16'hFFFF -> a single cycle with registerWrite=11, regWriteLocal=5, dataWrite=16'h0051, r0Write=16'hFFFF.
- Collision: ALU (R2, 16'hAAAA) and MEM (R7, 16'hBBBB) in the same cycle -> R2 write, then R7 write on consecutive cycles. While R7 is queued, queryB=7 gives pendingB=1; it clears after issue.
- Backpressure: ALU and MEM both valid every cycle for 10 cycles with DEPTH=4 -> stall rises once count reaches 3; no request is lost or duplicated while producers hold; issued order matches the scoreboard exactly.
- R0 hazard: queued ALU request with aluR0En=1 (aluDest=9), queryA=0 -> pendingA=1; with queryA=9 -> pendingA=1; with queryA=4 -> pendingA=0.

Source files
------------

// File: rtl/writeback_queue.sv
// Write-side front end for the 16x16 register file: merges ALU and load-return
// results, buffers collisions and issues one write command per cycle.
module writeback_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        aluValid,
  input  logic        aluDestEn,
  input  logic [3:0]  aluDest,
  input  logic [15:0] aluResult,
  input  logic        aluR0En,
  input  logic [15:0] aluR0Result,
  input  logic        memValid,
  input  logic [3:0]  memDest,
  input  logic [15:0] memData,
  output logic        stall,
  output logic [1:0]  registerWrite,
  output logic [3:0]  regWriteLocal,
  output logic [15:0] dataWrite,
  output logic [15:0] r0Write,
  input  logic [3:0]  queryA,
  input  logic [3:0]  queryB,
  output logic        pendingA,
  output logic        pendingB
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic        d_en;
    logic [3:0]  dest;
    logic [15:0] d_data;
    logic        r0_en;
    logic [15:0] r0_data;
  } wb_entry_t;

  wb_entry_t        fifo_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic      alu_acc, mem_acc, fifo_has;
  wb_entry_t alu_entry, mem_entry, first_entry;
  logic      first_v, second_v;
  wb_entry_t load_entry, push0, push1;
  logic      load_v, push0_v, push1_v;

  assign stall    = count_q > CNT_W'(DEPTH - 2);
  assign fifo_has = count_q != '0;
  assign alu_acc  = !stall && aluValid && (aluDestEn || aluR0En);
  assign mem_acc  = !stall && memValid;

  assign alu_entry   = '{aluDestEn, aluDest, aluResult, aluR0En, aluR0Result};
  assign mem_entry   = '{1'b1, memDest, memData, 1'b0, 16'h0000};
  assign first_v     = alu_acc || mem_acc;
  assign first_entry = alu_acc ? alu_entry : mem_entry;
  assign second_v    = alu_acc && mem_acc;

  // Oldest candidate goes to the output stage, the rest are pushed in age order
  always_comb begin
    load_v     = 1'b0;
    load_entry = '0;
    push0_v    = 1'b0;
    push0      = '0;
    push1_v    = 1'b0;
    push1      = '0;
    if (fifo_has) begin
      load_v     = 1'b1;
      load_entry = fifo_q[rd_ptr_q];
      push0_v    = first_v;
      push0      = first_entry;
      push1_v    = second_v;
      push1      = mem_entry;
    end else begin
      load_v     = first_v;
      load_entry = first_entry;
      push0_v    = second_v;
      push0      = mem_entry;
    end
    count_d  = count_q + CNT_W'(push0_v) + CNT_W'(push1_v) - CNT_W'(fifo_has);
    wr_ptr_d = wr_ptr_q + PTR_W'(push0_v) + PTR_W'(push1_v);
    rd_ptr_d = rd_ptr_q + PTR_W'(fifo_has);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Entry storage carries no reset; liveness comes from the pointers and count
  always_ff @(posedge clk) begin
    if (push0_v) fifo_q[wr_ptr_q] <= push0;
    if (push1_v) fifo_q[wr_ptr_q + PTR_W'(1)] <= push1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      registerWrite <= 2'b00;
      regWriteLocal <= 4'h0;
      dataWrite     <= 16'h0000;
      r0Write       <= 16'h0000;
    end else begin
      registerWrite <= load_v ? {load_entry.r0_en, load_entry.d_en} : 2'b00;
      if (load_v) begin
        regWriteLocal <= load_entry.dest;
        dataWrite     <= load_entry.d_data;
        r0Write       <= load_entry.r0_data;
      end
    end
  end

  function automatic logic entry_hits(input wb_entry_t e, input logic [3:0] q);
    return (e.d_en && (e.dest == q)) || (e.r0_en && (q == 4'h0));
  endfunction

  logic [PTR_W-1:0] ent_off  [DEPTH];
  logic [DEPTH-1:0] ent_live;

  // Hazards cover the output stage plus every live FIFO slot
  always_comb begin
    pendingA = (registerWrite[0] && (regWriteLocal == queryA)) ||
               (registerWrite[1] && (queryA == 4'h0));
    pendingB = (registerWrite[0] && (regWriteLocal == queryB)) ||
               (registerWrite[1] && (queryB == 4'h0));
    for (int i = 0; i < int'(DEPTH); i++) begin
      ent_off[i]  = PTR_W'(i) - rd_ptr_q;
      ent_live[i] = CNT_W'(ent_off[i]) < count_q;
      if (ent_live[i] && entry_hits(fifo_q[i], queryA)) pendingA = 1'b1;
      if (ent_live[i] && entry_hits(fifo_q[i], queryB)) pendingB = 1'b1;
    end
  end

endmodule
